// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: source/size selectors and FSM states.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LS_BYTE  = 2'd0,
        LS_HALF  = 2'd1,
        LS_WORD  = 2'd2,
        LS_DWORD = 2'd3
    } load_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_WRITE = 2'd2
    } wb_state_e;

    localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Combinational load lane selection and sign/zero extension from an aligned doubleword.
module load_extract
    import writeback_stage_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  offset_i,
    input  load_size_e  size_i,
    input  logic        unsigned_i,
    output logic [63:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] word_lane;

    // Offsets are aligned down to the access size before picking the lane.
    assign byte_lane = data_i[{offset_i, 3'b000} +: 8];
    assign half_lane = data_i[{offset_i[2:1], 4'b0000} +: 16];
    assign word_lane = data_i[{offset_i[2], 5'b00000} +: 32];

    always_comb begin
        result_o = data_i;
        case (size_i)
            LS_BYTE:  result_o = unsigned_i ? {56'd0, byte_lane}
                                            : {{56{byte_lane[7]}}, byte_lane};
            LS_HALF:  result_o = unsigned_i ? {48'd0, half_lane}
                                            : {{48{half_lane[15]}}, half_lane};
            LS_WORD:  result_o = unsigned_i ? {32'd0, word_lane}
                                            : {{32{word_lane[31]}}, word_lane};
            default:  result_o = data_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch plus IDLE/HOLD/WRITE handshake FSM driving the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_done,
    input  logic [63:0] loaded_data,
    input  logic [63:0] alu_data,
    input  logic [63:0] pc,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic [1:0]  wb_sel,
    input  logic [1:0]  load_size,
    input  logic        load_unsigned,
    output logic        mem_wb_pipeline_valid,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_addr,
    output logic [63:0] rf_write_data,
    output logic        wb_done,
    output logic [63:0] retired_count
);

    wb_state_e   state_q, state_d;
    logic [63:0] loaded_q, alu_q, pc_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    wb_sel_e     wb_sel_q;
    load_size_e  load_size_q;
    logic        load_unsigned_q;
    logic        capture;
    logic [63:0] load_value;
    logic [63:0] wb_value;

    assign capture = (state_q == ST_IDLE) && memory_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (memory_done)  state_d = ST_HOLD;
            ST_HOLD:  if (!memory_done) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture happens only from IDLE, so a lingering memory_done cannot overwrite a held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_q        <= 64'd0;
            alu_q           <= 64'd0;
            pc_q            <= 64'd0;
            rd_q            <= 5'd0;
            reg_write_q     <= 1'b0;
            wb_sel_q        <= WB_SEL_ALU;
            load_size_q     <= LS_BYTE;
            load_unsigned_q <= 1'b0;
        end else if (capture) begin
            loaded_q        <= loaded_data;
            alu_q           <= alu_data;
            pc_q            <= pc;
            rd_q            <= rd;
            reg_write_q     <= reg_write;
            wb_sel_q        <= wb_sel_e'(wb_sel);
            load_size_q     <= load_size_e'(load_size);
            load_unsigned_q <= load_unsigned;
        end
    end

    load_extract u_load_extract (
        .data_i     (loaded_q),
        .offset_i   (alu_q[2:0]),
        .size_i     (load_size_q),
        .unsigned_i (load_unsigned_q),
        .result_o   (load_value)
    );

    always_comb begin
        case (wb_sel_q)
            WB_SEL_LOAD: wb_value = load_value;
            WB_SEL_PC4:  wb_value = pc_q + PC_STEP;
            default:     wb_value = alu_q;
        endcase
    end

    // Outputs are forced low while reset is high so an aborted WRITE never strobes the file.
    always_comb begin
        mem_wb_pipeline_valid = 1'b0;
        rf_write_enable       = 1'b0;
        rf_write_addr         = 5'd0;
        rf_write_data         = 64'd0;
        wb_done               = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_HOLD:  mem_wb_pipeline_valid = 1'b1;
                ST_WRITE: begin
                    wb_done         = 1'b1;
                    rf_write_addr   = rd_q;
                    rf_write_data   = wb_value;
                    rf_write_enable = reg_write_q && (rd_q != 5'd0);
                end
                default: ;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= 64'd0;
        end else if (state_q == ST_WRITE) begin
            retired_q <= retired_q + 64'd1;
        end
    end

    assign retired_count = reset ? 64'd0 : retired_q;
`else
    assign retired_count = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Table-driven bench for writeback_stage with a scoreboard of expected register-file writes.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_done;
    logic [63:0] loaded_data, alu_data, pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  wb_sel, load_size;
    logic        load_unsigned;
    logic        mem_wb_pipeline_valid, rf_write_enable, wb_done;
    logic [4:0]  rf_write_addr;
    logic [63:0] rf_write_data, retired_count;

    writeback_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .memory_done           (memory_done),
        .loaded_data           (loaded_data),
        .alu_data              (alu_data),
        .pc                    (pc),
        .rd                    (rd),
        .reg_write             (reg_write),
        .wb_sel                (wb_sel),
        .load_size             (load_size),
        .load_unsigned         (load_unsigned),
        .mem_wb_pipeline_valid (mem_wb_pipeline_valid),
        .rf_write_enable       (rf_write_enable),
        .rf_write_addr         (rf_write_addr),
        .rf_write_data         (rf_write_data),
        .wb_done               (wb_done),
        .retired_count         (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] loaded;
        logic [63:0] alu;
        logic [63:0] pcv;
        logic [4:0]  rdv;
        logic        rw;
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        int          hold;
        logic        md_write;
        logic        exp_we;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] exp_cnt = 64'd0;
    exp_t        sb[$];
    vec_t        vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] loaded, input logic [63:0] alu,
                                input logic [63:0] pcv, input logic [4:0] rdv, input logic rw,
                                input logic [1:0] sel, input logic [1:0] size, input logic uns,
                                input int hold, input logic md_write,
                                input logic exp_we, input logic [63:0] exp_data);
        vec_t v;
        v.loaded = loaded; v.alu = alu; v.pcv = pcv; v.rdv = rdv; v.rw = rw;
        v.sel = sel; v.size = size; v.uns = uns; v.hold = hold; v.md_write = md_write;
        v.exp_we = exp_we; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        loaded_data   = v.loaded;
        alu_data      = v.alu;
        pc            = v.pcv;
        rd            = v.rdv;
        reg_write     = v.rw;
        wb_sel        = v.sel;
        load_size     = v.size;
        load_unsigned = v.uns;
    endtask

    task automatic scramble();
        loaded_data   = {$urandom, $urandom};
        alu_data      = {$urandom, $urandom};
        pc            = {$urandom, $urandom};
        rd            = 5'($urandom);
        reg_write     = 1'($urandom);
        wb_sel        = 2'($urandom);
        load_size     = 2'($urandom);
        load_unsigned = 1'($urandom);
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at the negedge of the following IDLE cycle.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        logic seen;
        drive(v);
        memory_done = 1'b1;
        e.we = v.exp_we; e.addr = v.rdv; e.data = v.exp_data;
        sb.push_back(e);
        @(negedge clk);
        check("valid_in_hold", mem_wb_pipeline_valid, 1);
        check("we_in_hold", rf_write_enable, 0);
        scramble();
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("valid_held", mem_wb_pipeline_valid, 1);
        end
        memory_done = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 4) begin
            @(negedge clk);
            lat++;
            if (wb_done) seen = 1'b1;
        end
        check("wb_latency", 64'(lat), 64'd1);
        e = sb.pop_front();
        if (seen) begin
            check("rf_we", rf_write_enable, e.we);
            check("rf_addr", rf_write_addr, e.addr);
            check("rf_data", rf_write_data, e.data);
            check("valid_in_write", mem_wb_pipeline_valid, 0);
`ifdef WB_RETIRE_CNT_EN
            exp_cnt = exp_cnt + 64'd1;
`endif
        end
        if (v.md_write) memory_done = 1'b1;
        @(negedge clk);
        check("valid_idle", mem_wb_pipeline_valid, 0);
        check("wb_done_idle", wb_done, 0);
        check("addr_idle", rf_write_addr, 0);
        check("data_idle", rf_write_data, 0);
        check("retired_count", retired_count, exp_cnt);
        memory_done = 1'b0;
        $display("txn %0d rd=%0d we=%0b data=%h count=%0d", idx, e.addr, e.we, e.data, retired_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0]  = mk(64'h0000_0000_8000_0000, 64'h1003, 64'h100, 5'd5, 1, 2'd1, 2'd0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[1]  = mk(64'hBEEF_0000_0000_0000, 64'h2006, 64'h104, 5'd6, 1, 2'd1, 2'd1, 1, 1, 0, 1, 64'h0000_0000_0000_BEEF);
        vecs[2]  = mk(64'h0000_0000_0000_DEAD, 64'h55, 64'h108, 5'd0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 64'h55);
        vecs[3]  = mk(64'd0, 64'h77, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1, 2'd2, 2'd0, 0, 1, 0, 1, 64'd0);
        vecs[4]  = mk(64'hFFFF, 64'h1234_5678_9ABC_DEF0, 64'h200, 5'd31, 1, 2'd3, 2'd3, 0, 0, 0, 1, 64'h1234_5678_9ABC_DEF0);
        vecs[5]  = mk(64'h8765_4321_0000_0000, 64'h4, 64'd0, 5'd7, 1, 2'd1, 2'd2, 0, 0, 0, 1, 64'hFFFF_FFFF_8765_4321);
        vecs[6]  = mk(64'h1111_2222_F333_4444, 64'h3, 64'd0, 5'd8, 1, 2'd1, 2'd2, 1, 2, 0, 1, 64'h0000_0000_F333_4444);
        vecs[7]  = mk(64'h8000_0000_0000_0001, 64'h7, 64'd0, 5'd9, 1, 2'd1, 2'd3, 0, 0, 1, 1, 64'h8000_0000_0000_0001);
        vecs[8]  = mk(64'h0000_0000_9ABC_0000, 64'h3, 64'd0, 5'd10, 1, 2'd1, 2'd1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_9ABC);
        vecs[9]  = mk(64'hA500_0000_0000_0000, 64'hF, 64'd0, 5'd11, 1, 2'd1, 2'd0, 1, 0, 0, 1, 64'h0000_0000_0000_00A5);
        vecs[10] = mk(64'd0, 64'h99, 64'h1000, 5'd12, 0, 2'd2, 2'd0, 0, 0, 0, 0, 64'h1004);
        vecs[11] = mk(64'h0000_0000_0000_007F, 64'h8, 64'd0, 5'd13, 1, 2'd1, 2'd0, 0, 0, 0, 1, 64'h7F);

        reset = 1'b1;
        memory_done = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        check("rst_valid", mem_wb_pipeline_valid, 0);
        check("rst_we", rf_write_enable, 0);
        check("rst_wb_done", wb_done, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_count", retired_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid", mem_wb_pipeline_valid, 0);
        check("post_rst_addr", rf_write_addr, 0);

        // Reset during HOLD aborts the instruction.
        v = mk(64'd0, 64'h42, 64'd0, 5'd4, 1, 2'd0, 2'd0, 0, 0, 0, 1, 64'h42);
        drive(v);
        memory_done = 1'b1;
        @(negedge clk);
        check("abort_hold_valid", mem_wb_pipeline_valid, 1);
        reset = 1'b1;
        memory_done = 1'b0;
        #1;
        check("abort_hold_valid_rst", mem_wb_pipeline_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_hold_no_done", wb_done, 0);
            check("abort_hold_no_we", rf_write_enable, 0);
        end
        check("abort_hold_count", retired_count, 0);
        $display("txn abort-in-hold rd=4 count=%0d", retired_count);

        // Reset during WRITE suppresses the strobe in that very cycle.
        drive(v);
        memory_done = 1'b1;
        @(negedge clk);
        memory_done = 1'b0;
        @(negedge clk);
        check("abort_write_pre_we", rf_write_enable, 1);
        reset = 1'b1;
        #1;
        check("abort_write_we", rf_write_enable, 0);
        check("abort_write_done", wb_done, 0);
        check("abort_write_data", rf_write_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_write_idle_done", wb_done, 0);
        check("abort_write_count", retired_count, 0);
        exp_cnt = 64'd0;
        $display("txn abort-in-write rd=4 count=%0d", retired_count);

        for (int i = 0; i < 12; i++) apply(vecs[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
